// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Sequential test stage around a 4-input / 3-output combinational function
// block. It steps A..D through all 16 codes, holds each code for HOLD
// cycles, and captures F_alpha/F_beta/F_gamma on the last cycle of each
// hold window into three 16-bit truth tables and three minterm counts.
//
// Parameters
//   HOLD       cycles each vector is held before sampling (1..15)
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   start      begins a sweep; only looked at while idle
//   F_alpha/F_beta/F_gamma  responses of the function block to A..D
//   A,B,C,D    registered vector, A is the MSB
//   busy       sweep in progress
//   done       one-cycle pulse after the last sample
//   valid      tables and counts hold a complete sweep
//   tt_*       truth tables, bit i = response at vector i
//   cnt_*      number of set bits in the matching table (0..16)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; results from the last sweep are held
// SWEEP | stepping idx through 0..15, sampling once per HOLD cycles

module truth_table_sweeper #(
    parameter int HOLD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        F_alpha,
    input  logic        F_beta,
    input  logic        F_gamma,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [15:0] tt_alpha,
    output logic [15:0] tt_beta,
    output logic [15:0] tt_gamma,
    output logic [4:0]  cnt_alpha,
    output logic [4:0]  cnt_beta,
    output logic [4:0]  cnt_gamma
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [3:0]  hold_cnt, hold_cnt_nxt;
    logic        busy_nxt, done_nxt, valid_nxt;
    logic [15:0] tt_alpha_nxt, tt_beta_nxt, tt_gamma_nxt;
    logic [4:0]  cnt_alpha_nxt, cnt_beta_nxt, cnt_gamma_nxt;

    // The vector outputs come straight off the idx register, so the
    // function block sees a glitch-free code for the whole hold window.
    assign {A, B, C, D} = idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= 4'd0;
            hold_cnt  <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            tt_alpha  <= 16'd0;
            tt_beta   <= 16'd0;
            tt_gamma  <= 16'd0;
            cnt_alpha <= 5'd0;
            cnt_beta  <= 5'd0;
            cnt_gamma <= 5'd0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            hold_cnt  <= hold_cnt_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            valid     <= valid_nxt;
            tt_alpha  <= tt_alpha_nxt;
            tt_beta   <= tt_beta_nxt;
            tt_gamma  <= tt_gamma_nxt;
            cnt_alpha <= cnt_alpha_nxt;
            cnt_beta  <= cnt_beta_nxt;
            cnt_gamma <= cnt_gamma_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        hold_cnt_nxt  = hold_cnt;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        valid_nxt     = valid;
        tt_alpha_nxt  = tt_alpha;
        tt_beta_nxt   = tt_beta;
        tt_gamma_nxt  = tt_gamma;
        cnt_alpha_nxt = cnt_alpha;
        cnt_beta_nxt  = cnt_beta;
        cnt_gamma_nxt = cnt_gamma;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = SWEEP;
                    idx_nxt       = 4'd0;
                    hold_cnt_nxt  = 4'd0;
                    busy_nxt      = 1'b1;
                    valid_nxt     = 1'b0;
                    tt_alpha_nxt  = 16'd0;
                    tt_beta_nxt   = 16'd0;
                    tt_gamma_nxt  = 16'd0;
                    cnt_alpha_nxt = 5'd0;
                    cnt_beta_nxt  = 5'd0;
                    cnt_gamma_nxt = 5'd0;
                end
            end

            SWEEP: begin
                if (hold_cnt != HOLD_LAST) begin
                    hold_cnt_nxt = hold_cnt + 4'd1;
                end else begin
                    // Sample edge: capture the settled response for this code.
                    tt_alpha_nxt[idx] = F_alpha;
                    tt_beta_nxt[idx]  = F_beta;
                    tt_gamma_nxt[idx] = F_gamma;
                    // At most 16 increments from zero, so 5 bits never wrap.
                    cnt_alpha_nxt     = cnt_alpha + {4'd0, F_alpha};
                    cnt_beta_nxt      = cnt_beta  + {4'd0, F_beta};
                    cnt_gamma_nxt     = cnt_gamma + {4'd0, F_gamma};
                    hold_cnt_nxt      = 4'd0;
                    if (idx == 4'hF) begin
                        idx_nxt   = 4'd0;
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        valid_nxt = 1'b1;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt = idx + 4'd1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper
// Two sweepers (HOLD=1 and HOLD=3) each drive a stub function block whose
// three outputs are looked up from bench-owned 16-entry tables. The
// reference for a sweep is simply that table, its popcount, and the
// timeline "vector m/HOLD on cycle m, done on cycle 16*HOLD".

module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset;
    logic start_v [2];
    logic [15:0] lut_a, lut_b, lut_g;

    wire        a_w [2];
    wire        b_w [2];
    wire        c_w [2];
    wire        d_w [2];
    wire        fa_w [2];
    wire        fb_w [2];
    wire        fg_w [2];
    wire        busy_w [2];
    wire        done_w [2];
    wire        valid_w [2];
    wire [15:0] tta_w [2];
    wire [15:0] ttb_w [2];
    wire [15:0] ttg_w [2];
    wire [4:0]  cna_w [2];
    wire [4:0]  cnb_w [2];
    wire [4:0]  cng_w [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        assign fa_w[g] = lut_a[{a_w[g], b_w[g], c_w[g], d_w[g]}];
        assign fb_w[g] = lut_b[{a_w[g], b_w[g], c_w[g], d_w[g]}];
        assign fg_w[g] = lut_g[{a_w[g], b_w[g], c_w[g], d_w[g]}];

        truth_table_sweeper #(.HOLD((g == 0) ? 1 : 3)) dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start_v[g]),
            .F_alpha   (fa_w[g]),
            .F_beta    (fb_w[g]),
            .F_gamma   (fg_w[g]),
            .A         (a_w[g]),
            .B         (b_w[g]),
            .C         (c_w[g]),
            .D         (d_w[g]),
            .busy      (busy_w[g]),
            .done      (done_w[g]),
            .valid     (valid_w[g]),
            .tt_alpha  (tta_w[g]),
            .tt_beta   (ttb_w[g]),
            .tt_gamma  (ttg_w[g]),
            .cnt_alpha (cna_w[g]),
            .cnt_beta  (cnb_w[g]),
            .cnt_gamma (cng_w[g])
        );
    end

    function automatic logic [3:0] vec_of(input int s);
        return {a_w[s], b_w[s], c_w[s], d_w[s]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int s, input string tag);
        chk({tag, "_vec"},   32'(vec_of(s)),  32'd0);
        chk({tag, "_busy"},  32'(busy_w[s]),  32'd0);
        chk({tag, "_done"},  32'(done_w[s]),  32'd0);
        chk({tag, "_valid"}, 32'(valid_w[s]), 32'd0);
        chk({tag, "_tta"},   32'(tta_w[s]),   32'd0);
        chk({tag, "_ttb"},   32'(ttb_w[s]),   32'd0);
        chk({tag, "_ttg"},   32'(ttg_w[s]),   32'd0);
        chk({tag, "_cna"},   32'(cna_w[s]),   32'd0);
        chk({tag, "_cnb"},   32'(cnb_w[s]),   32'd0);
        chk({tag, "_cng"},   32'(cng_w[s]),   32'd0);
    endtask

    task automatic chk_results(input int s, input string tag,
                               input logic [15:0] ea, input logic [15:0] eb,
                               input logic [15:0] eg);
        chk({tag, "_tta"}, 32'(tta_w[s]), 32'(ea));
        chk({tag, "_ttb"}, 32'(ttb_w[s]), 32'(eb));
        chk({tag, "_ttg"}, 32'(ttg_w[s]), 32'(eg));
        chk({tag, "_cna"}, 32'(cna_w[s]), 32'($countones(ea)));
        chk({tag, "_cnb"}, 32'(cnb_w[s]), 32'($countones(eb)));
        chk({tag, "_cng"}, 32'(cng_w[s]), 32'($countones(eg)));
    endtask

    // Called at a falling edge with the sweeper idle. Cycle m is the cycle
    // after the m-th rising edge following the start edge.
    // keep: leave start high so the next sweep begins right after done.
    // poke: vector index at which start is pulsed mid-sweep (-1 = none).
    task automatic sweep(input int s, input int h, input bit keep, input int poke,
                         input logic [15:0] ea, input logic [15:0] eb,
                         input logic [15:0] eg);
        int last;
        last = 16 * h;
        start_v[s] = 1'b1;
        @(posedge clk);
        for (int m = 0; m <= last; m++) begin
            @(negedge clk);
            if (m == 0 && !keep) start_v[s] = 1'b0;
            if (poke >= 0 && m == poke * h)     start_v[s] = 1'b1;
            if (poke >= 0 && m == poke * h + 1) start_v[s] = 1'b0;
            if (m == 0) begin
                chk("start_valid", 32'(valid_w[s]), 32'd0);
                chk("start_tta",   32'(tta_w[s]),   32'd0);
                chk("start_ttb",   32'(ttb_w[s]),   32'd0);
                chk("start_ttg",   32'(ttg_w[s]),   32'd0);
                chk("start_cna",   32'(cna_w[s]),   32'd0);
                chk("start_cng",   32'(cng_w[s]),   32'd0);
            end
            if (m < last) begin
                chk("run_vec",  32'(vec_of(s)), 32'((m / h) % 16));
                chk("run_busy", 32'(busy_w[s]), 32'd1);
                chk("run_done", 32'(done_w[s]), 32'd0);
            end else begin
                chk("end_vec",   32'(vec_of(s)),  32'd0);
                chk("end_busy",  32'(busy_w[s]),  32'd0);
                chk("end_done",  32'(done_w[s]),  32'd1);
                chk("end_valid", 32'(valid_w[s]), 32'd1);
                chk_results(s, "end", ea, eb, eg);
            end
        end
        if (!keep) begin
            @(negedge clk);
            chk("post_done",  32'(done_w[s]),  32'd0);
            chk("post_busy",  32'(busy_w[s]),  32'd0);
            chk("post_valid", 32'(valid_w[s]), 32'd1);
            chk_results(s, "post", ea, eb, eg);
        end
    endtask

    task automatic rand_luts();
        lut_a = 16'($urandom);
        lut_b = 16'($urandom);
        lut_g = 16'($urandom);
    endtask

    initial begin
        reset      = 1'b1;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        lut_a      = 16'd0;
        lut_b      = 16'd0;
        lut_g      = 16'd0;
        repeat (3) @(negedge clk);
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        reset = 1'b0;
        @(negedge clk);
        chk_zero(0, "idle0");

        // F_alpha=D, F_beta=A, F_gamma=A&B&C&D
        for (int v = 0; v < 16; v++) begin
            lut_a[v] = v[0];
            lut_b[v] = v[3];
            lut_g[v] = (v == 15);
        end
        sweep(0, 1, 1'b0, -1, 16'hAAAA, 16'hFF00, 16'h8000);

        lut_a = 16'hFFFF; lut_b = 16'hFFFF; lut_g = 16'hFFFF;
        sweep(0, 1, 1'b0, -1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        lut_a = 16'h0000; lut_b = 16'h0000; lut_g = 16'h0000;
        sweep(0, 1, 1'b0, -1, 16'h0000, 16'h0000, 16'h0000);

        // HOLD=3, F_alpha=C
        rand_luts();
        for (int v = 0; v < 16; v++) lut_a[v] = v[1];
        sweep(1, 3, 1'b0, -1, 16'hCCCC, lut_b, lut_g);

        // start pulsed while vector 5 is showing
        rand_luts();
        sweep(0, 1, 1'b0, 5, lut_a, lut_b, lut_g);
        rand_luts();
        sweep(1, 3, 1'b0, 5, lut_a, lut_b, lut_g);

        // start held high: back-to-back sweeps, tables re-cleared each time
        rand_luts();
        sweep(0, 1, 1'b1, -1, lut_a, lut_b, lut_g);
        rand_luts();
        sweep(0, 1, 1'b1, -1, lut_a, lut_b, lut_g);
        rand_luts();
        sweep(0, 1, 1'b0, -1, lut_a, lut_b, lut_g);

        // reset while vector 9 is showing
        lut_a = 16'hFFFF; lut_b = 16'h0000; lut_g = 16'hFFFF;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_vec", 32'(vec_of(0)), 32'd9);
        chk("mid_tta", 32'(tta_w[0]), 32'h01FF);
        chk("mid_cna", 32'(cna_w[0]), 32'd9);
        reset = 1'b1;
        @(negedge clk);
        chk_zero(0, "midrst");
        reset = 1'b0;
        @(negedge clk);
        chk_zero(0, "midrst_idle");
        rand_luts();
        sweep(0, 1, 1'b0, -1, lut_a, lut_b, lut_g);

        // random tables on both hold settings
        for (int i = 0; i < 4; i++) begin
            rand_luts();
            sweep(0, 1, 1'b0, -1, lut_a, lut_b, lut_g);
            rand_luts();
            sweep(1, 3, 1'b0, -1, lut_a, lut_b, lut_g);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
